// File: rtl/laser_multi_scan.sv
// laser_multi_scan: two-circle coverage engine. It captures N points, then
// alternates exhaustive scans of centre C1 and centre C2 over the 2^W x 2^W
// grid until coverage stops improving or ROUNDS rounds have run. It then
// publishes both centres and the covered-point count with a one-cycle DONE.
module laser_multi_scan #(
  parameter int N      = 40,
  parameter int W      = 4,
  parameter int R2     = 16,
  parameter int ROUNDS = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   IN_VALID,
  input  logic [W-1:0]           X,
  input  logic [W-1:0]           Y,
  output logic [W-1:0]           C1X,
  output logic [W-1:0]           C1Y,
  output logic [W-1:0]           C2X,
  output logic [W-1:0]           C2Y,
  output logic [$clog2(N+1)-1:0] COVER,
  output logic                   DONE
);

  localparam int CNT_W = $clog2(N+1);
  localparam int RND_W = $clog2(ROUNDS+1);
  localparam int DEPTH = 1 << CNT_W;
  localparam int CW    = 2*W;
  localparam int SQ_W  = 2*W;

  localparam logic [31:0]      R2_U      = 32'(R2);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(N-1);
  localparam logic [CNT_W-1:0] CMP_SLOT  = CNT_W'(N);
  localparam logic [CW-1:0]    LAST_CAND = {CW{1'b1}};
  localparam logic [RND_W-1:0] MAX_RND   = RND_W'(ROUNDS);

  localparam logic [2:0] S_LOAD  = 3'd0;
  localparam logic [2:0] S_SCAN1 = 3'd1;
  localparam logic [2:0] S_SCAN2 = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Point (px,py) lies within R2 of centre (cx,cy). The sum of squares is at
  // most 2W+1 bits, so zero-extending it to 32 bits compares without wrap.
  function automatic logic covers(input logic [W-1:0] px, input logic [W-1:0] py,
                                  input logic [W-1:0] cx, input logic [W-1:0] cy);
    logic signed [W:0]     dx;
    logic signed [W:0]     dy;
    logic signed [2*W+1:0] dxe;
    logic signed [2*W+1:0] dye;
    logic [SQ_W-1:0]       sqx;
    logic [SQ_W-1:0]       sqy;
    logic [SQ_W:0]         sum;
    dx  = $signed({1'b0, px}) - $signed({1'b0, cx});
    dy  = $signed({1'b0, py}) - $signed({1'b0, cy});
    dxe = {{(W+1){dx[W]}}, dx};
    dye = {{(W+1){dy[W]}}, dy};
    sqx = SQ_W'(dxe * dxe);
    sqy = SQ_W'(dye * dye);
    sum = {1'b0, sqx} + {1'b0, sqy};
    return 32'(sum) <= R2_U;
  endfunction

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] pt_q, pt_d;
  logic [CW-1:0]    cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] best_q, best_d;
  logic [CNT_W-1:0] best_start_q, best_start_d;
  logic [RND_W-1:0] round_q, round_d;
  logic             c2_en_q, c2_en_d;
  logic [W-1:0]     c1x_q, c1x_d, c1y_q, c1y_d, c2x_q, c2x_d, c2y_q, c2y_d;
  logic [W-1:0]     o_c1x_q, o_c1x_d, o_c1y_q, o_c1y_d;
  logic [W-1:0]     o_c2x_q, o_c2x_d, o_c2y_q, o_c2y_d;
  logic [CNT_W-1:0] o_cov_q, o_cov_d;
  logic [W-1:0]     pts_x_q [DEPTH];
  logic [W-1:0]     pts_y_q [DEPTH];
  logic             wr_en;
  logic [W-1:0]     cand_x, cand_y, pt_x, pt_y, fix_x, fix_y;
  logic             fix_en, hit;

  assign cand_x = cand_q[W-1:0];
  assign cand_y = cand_q[CW-1:W];
  assign pt_x   = pts_x_q[pt_q];
  assign pt_y   = pts_y_q[pt_q];

  // Hit test of the current point against the candidate and the fixed centre.
  always_comb begin
    if (state_q == S_SCAN2) begin
      fix_x  = c1x_q;
      fix_y  = c1y_q;
      fix_en = 1'b1;
    end else begin
      fix_x  = c2x_q;
      fix_y  = c2y_q;
      fix_en = c2_en_q;
    end
    hit = covers(pt_x, pt_y, cand_x, cand_y) | (fix_en & covers(pt_x, pt_y, fix_x, fix_y));
  end

  // Next-state logic: load, scan accumulate/compare, round check, publish.
  always_comb begin
    state_d      = state_q;
    pt_d         = pt_q;
    cand_d       = cand_q;
    cnt_d        = cnt_q;
    best_d       = best_q;
    best_start_d = best_start_q;
    round_d      = round_q;
    c2_en_d      = c2_en_q;
    c1x_d        = c1x_q;
    c1y_d        = c1y_q;
    c2x_d        = c2x_q;
    c2y_d        = c2y_q;
    o_c1x_d      = o_c1x_q;
    o_c1y_d      = o_c1y_q;
    o_c2x_d      = o_c2x_q;
    o_c2y_d      = o_c2y_q;
    o_cov_d      = o_cov_q;
    wr_en        = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (IN_VALID) begin
          wr_en = 1'b1;
          if (pt_q == LAST_SLOT) begin
            // Last point captured: start a fresh pattern search.
            state_d      = S_SCAN1;
            pt_d         = '0;
            cand_d       = '0;
            cnt_d        = '0;
            best_d       = '0;
            best_start_d = '0;
            round_d      = RND_W'(1);
            c2_en_d      = 1'b0;
            c1x_d        = '0;
            c1y_d        = '0;
            c2x_d        = '0;
            c2y_d        = '0;
          end else begin
            pt_d = pt_q + CNT_W'(1);
          end
        end
      end
      S_SCAN1, S_SCAN2: begin
        if (pt_q != CMP_SLOT) begin
          if (hit) cnt_d = cnt_q + CNT_W'(1);
          pt_d = pt_q + CNT_W'(1);
        end else begin
          // Compare cycle: strict improvement only, so ties keep the earlier candidate.
          if (cnt_q > best_q) begin
            best_d = cnt_q;
            if (state_q == S_SCAN1) begin
              c1x_d = cand_x;
              c1y_d = cand_y;
            end else begin
              c2x_d = cand_x;
              c2y_d = cand_y;
            end
          end
          cnt_d  = '0;
          pt_d   = '0;
          cand_d = cand_q + CW'(1);
          if (cand_q == LAST_CAND) begin
            if (state_q == S_SCAN1) begin
              state_d = S_SCAN2;
              // Seeding C2 on top of C1 keeps best equal to the joint coverage.
              if (!c2_en_q) begin
                c2x_d   = c1x_d;
                c2y_d   = c1y_d;
                c2_en_d = 1'b1;
              end
            end else begin
              state_d = S_CHECK;
            end
          end
        end
      end
      S_CHECK: begin
        if ((best_q == best_start_q) || (round_q == MAX_RND)) begin
          state_d = S_DONE;
          o_c1x_d = c1x_q;
          o_c1y_d = c1y_q;
          o_c2x_d = c2x_q;
          o_c2y_d = c2y_q;
          o_cov_d = best_q;
        end else begin
          state_d      = S_SCAN1;
          round_d      = round_q + RND_W'(1);
          best_start_d = best_q;
        end
      end
      S_DONE: begin
        state_d = S_LOAD;
        pt_d    = '0;
      end
      default: begin
        state_d = S_LOAD;
        pt_d    = '0;
      end
    endcase
  end

  // Control and published results, asynchronously cleared.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_LOAD;
      pt_q         <= '0;
      cand_q       <= '0;
      cnt_q        <= '0;
      best_q       <= '0;
      best_start_q <= '0;
      round_q      <= '0;
      c2_en_q      <= 1'b0;
      o_c1x_q      <= '0;
      o_c1y_q      <= '0;
      o_c2x_q      <= '0;
      o_c2y_q      <= '0;
      o_cov_q      <= '0;
    end else begin
      state_q      <= state_d;
      pt_q         <= pt_d;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      best_q       <= best_d;
      best_start_q <= best_start_d;
      round_q      <= round_d;
      c2_en_q      <= c2_en_d;
      o_c1x_q      <= o_c1x_d;
      o_c1y_q      <= o_c1y_d;
      o_c2x_q      <= o_c2x_d;
      o_c2y_q      <= o_c2y_d;
      o_cov_q      <= o_cov_d;
    end
  end

  // Point store and working centres; both are initialised before use each pattern.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      pts_x_q[pt_q] <= X;
      pts_y_q[pt_q] <= Y;
    end
    c1x_q <= c1x_d;
    c1y_q <= c1y_d;
    c2x_q <= c2x_d;
    c2y_q <= c2y_d;
  end

  assign C1X   = o_c1x_q;
  assign C1Y   = o_c1y_q;
  assign C2X   = o_c2x_q;
  assign C2Y   = o_c2y_q;
  assign COVER = o_cov_q;
  assign DONE  = (state_q == S_DONE);

endmodule

// File: tb/tb_laser_multi_scan.sv
// Testbench for laser_multi_scan: a default-parameter instance plus two small
// W=2/N=4/R2=1 instances (ROUNDS 2 and 1) sharing one stimulus stream, all
// checked against a plain-loop reference of the alternating search.
module tb_laser_multi_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance.
  logic       rst_a, vld_a;
  logic [3:0] x_a, y_a, c1x_a, c1y_a, c2x_a, c2y_a;
  logic [5:0] cov_a;
  logic       done_a;

  // Small instances share reset and point stream.
  logic       rst_s, vld_s;
  logic [1:0] x_s, y_s;
  logic [1:0] c1x_b, c1y_b, c2x_b, c2y_b, c1x_c, c1y_c, c2x_c, c2y_c;
  logic [2:0] cov_b, cov_c;
  logic       done_b, done_c;

  laser_multi_scan dut_a (
    .CLK(clk), .RST(rst_a), .IN_VALID(vld_a), .X(x_a), .Y(y_a),
    .C1X(c1x_a), .C1Y(c1y_a), .C2X(c2x_a), .C2Y(c2y_a), .COVER(cov_a), .DONE(done_a)
  );

  laser_multi_scan #(.N(4), .W(2), .R2(1), .ROUNDS(2)) dut_b (
    .CLK(clk), .RST(rst_s), .IN_VALID(vld_s), .X(x_s), .Y(y_s),
    .C1X(c1x_b), .C1Y(c1y_b), .C2X(c2x_b), .C2Y(c2y_b), .COVER(cov_b), .DONE(done_b)
  );

  laser_multi_scan #(.N(4), .W(2), .R2(1), .ROUNDS(1)) dut_c (
    .CLK(clk), .RST(rst_s), .IN_VALID(vld_s), .X(x_s), .Y(y_s),
    .C1X(c1x_c), .C1Y(c1y_c), .C2X(c2x_c), .C2Y(c2y_c), .COVER(cov_c), .DONE(done_c)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Results captured at DONE.
  int ra[5];
  int lat_a, hold_bad_a;
  int rb[5];
  int rc[5];
  int lat_b, lat_c, hi_b, hi_c;

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int dist2(input int ax, input int ay, input int bx, input int by);
    return (ax - bx) * (ax - bx) + (ay - by) * (ay - by);
  endfunction

  // Reference: plain nested loops over rounds, centres, grid and points.
  task automatic ref_model(input int w, input int n, input int r2, input int rounds,
                           input int px[$], input int py[$], output int res[6]);
    int side, best, start, h, cnt;
    int cx[2];
    int cy[2];
    bit en;
    side = 1 << w;
    cx[0] = 0; cy[0] = 0; cx[1] = 0; cy[1] = 0;
    best = 0; en = 1'b0; h = 0;
    for (int r = 1; r <= rounds; r++) begin
      start = best;
      for (int ph = 0; ph < 2; ph++) begin
        if (ph == 1 && !en) begin
          cx[1] = cx[0]; cy[1] = cy[0]; en = 1'b1;
        end
        for (int y = 0; y < side; y++) begin
          for (int x = 0; x < side; x++) begin
            cnt = 0;
            for (int i = 0; i < n; i++) begin
              if (dist2(px[i], py[i], x, y) <= r2 ||
                  (en && dist2(px[i], py[i], cx[1-ph], cy[1-ph]) <= r2))
                cnt++;
            end
            if (cnt > best) begin
              best = cnt; cx[ph] = x; cy[ph] = y;
            end
          end
        end
        h++;
      end
      if (best == start) break;
    end
    res[0] = cx[0]; res[1] = cy[0]; res[2] = cx[1]; res[3] = cy[1]; res[4] = best;
    res[5] = h * side * side * (n + 1) + h / 2 + 1;
  endtask

  task automatic load_a(input int px[$], input int py[$]);
    for (int i = 0; i < px.size(); i++) begin
      @(negedge clk);
      vld_a = 1'b1; x_a = 4'(px[i]); y_a = 4'(py[i]);
      @(posedge clk);
    end
    #1 vld_a = 1'b0;
  endtask

  // mode 0: back-to-back, 1: one idle cycle before each point, 2: random gaps.
  task automatic load_s(input int px[$], input int py[$], input int mode);
    int gap;
    for (int i = 0; i < px.size(); i++) begin
      gap = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (gap) begin
        @(negedge clk); vld_s = 1'b0;
        @(posedge clk);
      end
      @(negedge clk);
      vld_s = 1'b1; x_s = 2'(px[i]); y_s = 2'(py[i]);
      @(posedge clk);
    end
    #1 vld_s = 1'b0;
  endtask

  // Cycle 1 is the cycle after the final capture edge; outputs must hold h* until DONE.
  task automatic wait_a(input int budget, input int h0, input int h1, input int h2,
                        input int h3, input int h4);
    lat_a = -1; hold_bad_a = 0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      if (done_a) begin
        lat_a = cyc;
        ra[0] = int'(c1x_a); ra[1] = int'(c1y_a); ra[2] = int'(c2x_a);
        ra[3] = int'(c2y_a); ra[4] = int'(cov_a);
      end else if (int'(c1x_a) != h0 || int'(c1y_a) != h1 || int'(c2x_a) != h2 ||
                   int'(c2y_a) != h3 || int'(cov_a) != h4) begin
        hold_bad_a++;
      end
      if (lat_a >= 0) break;
    end
  endtask

  task automatic wait_s(input int ncyc);
    lat_b = -1; lat_c = -1; hi_b = 0; hi_c = 0;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(negedge clk);
      if (done_b) begin
        hi_b++;
        if (lat_b < 0) begin
          lat_b = cyc;
          rb[0] = int'(c1x_b); rb[1] = int'(c1y_b); rb[2] = int'(c2x_b);
          rb[3] = int'(c2y_b); rb[4] = int'(cov_b);
        end
      end
      if (done_c) begin
        hi_c++;
        if (lat_c < 0) begin
          lat_c = cyc;
          rc[0] = int'(c1x_c); rc[1] = int'(c1y_c); rc[2] = int'(c2x_c);
          rc[3] = int'(c2y_c); rc[4] = int'(cov_c);
        end
      end
    end
  endtask

  task automatic check_pair(input string tag, input int eb[6], input int ec[6]);
    string nm[5] = '{"c1x", "c1y", "c2x", "c2y", "cover"};
    for (int k = 0; k < 5; k++) begin
      check_val({tag, "_b_", nm[k]}, rb[k], eb[k]);
      check_val({tag, "_c_", nm[k]}, rc[k], ec[k]);
    end
    check_val({tag, "_b_latency"}, lat_b, eb[5]);
    check_val({tag, "_c_latency"}, lat_c, ec[5]);
    check_val({tag, "_b_done_cycles"}, hi_b, 1);
    check_val({tag, "_c_done_cycles"}, hi_c, 1);
  endtask

  task automatic run_default();
    int px[$];
    int py[$];
    int e[6];
    rst_a = 1'b1; vld_a = 1'b0; x_a = '0; y_a = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_a = 1'b0;
    @(negedge clk);
    check_val("a_rst_c1x", int'(c1x_a), 0);
    check_val("a_rst_c2y", int'(c2y_a), 0);
    check_val("a_rst_cover", int'(cov_a), 0);
    check_val("a_rst_done", int'(done_a), 0);
    // 40 points stacked at (3,3).
    for (int i = 0; i < 40; i++) begin px.push_back(3); py.push_back(3); end
    load_a(px, py);
    wait_a(45000, 0, 0, 0, 0, 0);
    check_val("a1_latency", lat_a, 41987);
    check_val("a1_c1x", ra[0], 1);
    check_val("a1_c1y", ra[1], 0);
    check_val("a1_c2x", ra[2], 1);
    check_val("a1_c2y", ra[3], 0);
    check_val("a1_cover", ra[4], 40);
    check_val("a1_hold", hold_bad_a, 0);
    // Second random pattern loaded straight after DONE, no reset.
    px.delete(); py.delete();
    for (int i = 0; i < 40; i++) begin
      px.push_back(int'($urandom_range(0, 15)));
      py.push_back(int'($urandom_range(0, 15)));
    end
    ref_model(4, 40, 16, 2, px, py, e);
    load_a(px, py);
    check_val("a2_hold_after_load_cover", int'(cov_a), 40);
    check_val("a2_hold_after_load_c1x", int'(c1x_a), 1);
    wait_a(45000, 1, 0, 1, 0, 40);
    check_val("a2_latency", lat_a, e[5]);
    check_val("a2_c1x", ra[0], e[0]);
    check_val("a2_c1y", ra[1], e[1]);
    check_val("a2_c2x", ra[2], e[2]);
    check_val("a2_c2y", ra[3], e[3]);
    check_val("a2_cover", ra[4], e[4]);
    check_val("a2_hold", hold_bad_a, 0);
    @(negedge clk);
    check_val("a2_done_width", int'(done_a), 0);
  endtask

  task automatic run_small();
    int px[$];
    int py[$];
    int eb[6];
    int ec[6];
    rst_s = 1'b1; vld_s = 1'b0; x_s = '0; y_s = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_s = 1'b0;
    @(negedge clk);
    check_val("s_rst_b_c1x", int'(c1x_b), 0);
    check_val("s_rst_b_c2y", int'(c2y_b), 0);
    check_val("s_rst_b_cover", int'(cov_b), 0);
    check_val("s_rst_c_cover", int'(cov_c), 0);
    check_val("s_rst_c_done", int'(done_c), 0);
    wait_s(1000);
    check_val("s_idle_b_done", hi_b, 0);
    check_val("s_idle_c_done", hi_c, 0);
    // Fixed case with an idle cycle before every point.
    px = '{0, 0, 3, 3};
    py = '{0, 0, 3, 3};
    eb = '{0, 0, 3, 2, 4, 323};
    ec = '{0, 0, 3, 2, 4, 162};
    load_s(px, py, 1);
    wait_s(340);
    check_pair("fix", eb, ec);
    // Abort mid-SCAN1, then reload the same points.
    load_s(px, py, 1);
    repeat (30) @(negedge clk);
    rst_s = 1'b1;
    #1;
    check_val("abort_b_c2x", int'(c2x_b), 0);
    check_val("abort_b_cover", int'(cov_b), 0);
    check_val("abort_c_c2y", int'(c2y_c), 0);
    check_val("abort_c_cover", int'(cov_c), 0);
    repeat (2) @(negedge clk);
    rst_s = 1'b0;
    wait_s(200);
    check_val("abort_b_no_done", hi_b, 0);
    check_val("abort_c_no_done", hi_c, 0);
    load_s(px, py, 1);
    wait_s(340);
    check_pair("reload", eb, ec);
    // Random patterns with random load gaps.
    for (int t = 0; t < 8; t++) begin
      px.delete(); py.delete();
      for (int i = 0; i < 4; i++) begin
        px.push_back(int'($urandom_range(0, 3)));
        py.push_back(int'($urandom_range(0, 3)));
      end
      ref_model(2, 4, 1, 2, px, py, eb);
      ref_model(2, 4, 1, 1, px, py, ec);
      load_s(px, py, 2);
      wait_s(340);
      check_pair($sformatf("rnd%0d", t), eb, ec);
    end
  endtask

  initial begin
    fork
      run_default();
      run_small();
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
